// File: rtl/ireq_arbiter_if.sv
// Stream bundle between the ireq requesters and the shared SRIO ireq master.
// The master modport is the arbiter side; slave is the requester/core side.
interface ireq_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 64,
    parameter int USER_W  = 32
);
    logic [NUM_REQ-1:0]          s_tvalid;
    logic [NUM_REQ-1:0]          s_tready;
    logic [NUM_REQ-1:0]          s_tlast;
    logic [NUM_REQ*DATA_W-1:0]   s_tdata;
    logic [NUM_REQ*DATA_W/8-1:0] s_tkeep;
    logic [NUM_REQ*USER_W-1:0]   s_tuser;
    logic                        m_tvalid;
    logic                        m_tready;
    logic                        m_tlast;
    logic [DATA_W-1:0]           m_tdata;
    logic [DATA_W/8-1:0]         m_tkeep;
    logic [USER_W-1:0]           m_tuser;

    modport master (
        input  s_tvalid, s_tlast, s_tdata, s_tkeep, s_tuser,
        input  m_tready,
        output s_tready,
        output m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser
    );

    modport slave (
        output s_tvalid, s_tlast, s_tdata, s_tkeep, s_tuser,
        output m_tready,
        input  s_tready,
        input  m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser
    );
endinterface

// File: rtl/ireq_arbiter.sv
// Packet-atomic round-robin arbiter sharing the SRIO ireq stream master.
// A grant is held from header beat to tlast; over-length packets are flagged.
module ireq_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int DATA_W    = 64,
    parameter int USER_W    = 32,
    parameter int MAX_BEATS = 33
) (
    input  logic               log_clk,
    input  logic               log_rst_n,
    input  logic               link_initialized,
    ireq_arbiter_if.master     bus,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic               len_err,
    output logic [2:0]         len_err_port,
    input  logic               err_clr
);
    localparam int KW = DATA_W / 8;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IW-1:0]      gidx_q;
    logic [IW-1:0]      rr_q;
    logic [7:0]         beat_q;
    logic               busy_q;
    logic               len_err_q;
    logic [2:0]         len_port_q;

    logic [IW-1:0]      c;
    logic [IW-1:0]      pick;
    logic               found;
    logic               acc;
    logic               ovf;

    // Search starts just after the last owner, so it has lowest priority.
    always_comb begin
        c     = rr_q;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = (c == IW'(NUM_REQ - 1)) ? '0 : c + 1'b1;
            if (!found && bus.s_tvalid[c]) begin
                found = 1'b1;
                pick  = c;
            end
        end
    end

    always_comb begin
        bus.m_tvalid = 1'b0;
        bus.m_tlast  = 1'b0;
        bus.m_tdata  = '0;
        bus.m_tkeep  = '0;
        bus.m_tuser  = '0;
        bus.s_tready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                bus.m_tvalid    = bus.s_tvalid[i];
                bus.m_tlast     = bus.s_tlast[i];
                bus.m_tdata     = bus.s_tdata[i*DATA_W +: DATA_W];
                bus.m_tkeep     = bus.s_tkeep[i*KW +: KW];
                bus.m_tuser     = bus.s_tuser[i*USER_W +: USER_W];
                bus.s_tready[i] = bus.m_tready;
            end
        end
    end

    assign acc = bus.m_tvalid & bus.m_tready;
    assign ovf = acc & ~bus.m_tlast
               & (beat_q == 8'(MAX_BEATS - 1));

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_q       <= IW'(NUM_REQ - 1);
            beat_q     <= '0;
            busy_q     <= 1'b0;
            len_err_q  <= 1'b0;
            len_port_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (link_initialized && found) begin
                        grant_q <= NUM_REQ'(1) << pick;
                        gidx_q  <= pick;
                        busy_q  <= 1'b1;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (acc && bus.m_tlast) begin
                        rr_q    <= gidx_q;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        beat_q  <= '0;
                        state_q <= IDLE;
                    end else if (acc && beat_q != 8'hFF) begin
                        beat_q <= beat_q + 8'd1;
                    end
                end
            endcase
            if (err_clr) begin
                len_err_q  <= 1'b0;
                len_port_q <= '0;
            end
            // Only the first error is latched; a same-cycle clear yields to it.
            if (ovf && (!len_err_q || err_clr)) begin
                len_err_q  <= 1'b1;
                len_port_q <= 3'(gidx_q);
            end
        end
    end

    assign grant        = grant_q;
    assign busy         = busy_q;
    assign len_err      = len_err_q;
    assign len_err_port = len_port_q;
endmodule

// File: tb/tb_ireq_arbiter.sv
// Bench for ireq_arbiter: directed scenarios then random traffic,
// checked cycle by cycle against a packet-level round-robin model.
module tb_ireq_arbiter;
    localparam int NR = 2;
    localparam int DW = 64;
    localparam int UW = 32;
    localparam int KW = DW / 8;
    localparam int MB = 33;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          link = 1'b0;
    logic          err_clr = 1'b0;
    logic [NR-1:0] grant;
    logic          busy;
    logic          len_err;
    logic [2:0]    len_err_port;

    ireq_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .USER_W(UW)) bus ();

    ireq_arbiter #(
        .NUM_REQ(NR), .DATA_W(DW), .USER_W(UW), .MAX_BEATS(MB)
    ) dut (
        .log_clk          (clk),
        .log_rst_n        (rst_n),
        .link_initialized (link),
        .bus              (bus),
        .grant            (grant),
        .busy             (busy),
        .len_err          (len_err),
        .len_err_port     (len_err_port),
        .err_clr          (err_clr)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    int    ncyc = 0;
    beat_t q[NR][$];
    bit    bub[NR];
    bit    rnd = 1'b0;
    int    done_q[$];
    int    done_len[$];
    int    mv_cnt;
    int    mv_first;

    // Model state: owner of the stream, last winner, beats in packet.
    bit    md_busy;
    int    md_own;
    int    md_last;
    int    md_bc;
    bit    md_le;
    int    md_lep;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic md_reset();
        md_busy = 0;
        md_own  = 0;
        md_last = NR - 1;
        md_bc   = 0;
        md_le   = 0;
        md_lep  = 0;
    endtask

    task automatic enq(input int p, input int n);
        beat_t b;
        logic [UW-1:0] u;
        u = $urandom;
        for (int i = 0; i < n; i++) begin
            b.d = {$urandom, $urandom};
            b.k = KW'($urandom);
            b.u = u;
            b.l = (i == n - 1);
            q[p].push_back(b);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (q[i].size() > 0 && !bub[i]) begin
                bus.s_tvalid[i]            = 1'b1;
                bus.s_tlast[i]             = q[i][0].l;
                bus.s_tdata[i*DW +: DW]    = q[i][0].d;
                bus.s_tkeep[i*KW +: KW]    = q[i][0].k;
                bus.s_tuser[i*UW +: UW]    = q[i][0].u;
            end else begin
                bus.s_tvalid[i]            = 1'b0;
                bus.s_tlast[i]             = 1'b0;
                bus.s_tdata[i*DW +: DW]    = '0;
                bus.s_tkeep[i*KW +: KW]    = '0;
                bus.s_tuser[i*UW +: UW]    = '0;
            end
        end
    endtask

    task automatic check_cycle();
        beat_t b;
        bit    ovf;
        bit    nle;
        int    nlep;
        int    p;
        bit    f;
        p = 0;
        ovf = 0;
        if (bus.m_tvalid === 1'b1) begin
            if (mv_cnt == 0) mv_first = ncyc;
            mv_cnt++;
        end
        chk("len_err", len_err, md_le);
        chk("len_err_port", len_err_port, md_lep);
        nle  = md_le;
        nlep = md_lep;
        if (err_clr) begin
            nle  = 0;
            nlep = 0;
        end
        if (!md_busy) begin
            chk("idle_grant", grant, 0);
            chk("idle_busy", busy, 0);
            chk("idle_m_tvalid", bus.m_tvalid, 0);
            chk("idle_s_tready", bus.s_tready, 0);
            chk("idle_m_tdata", bus.m_tdata, 0);
            chk("idle_m_tuser", bus.m_tuser, 0);
            chk("idle_m_tlast", bus.m_tlast, 0);
            if (link && (|bus.s_tvalid)) begin
                f = 0;
                for (int k = 1; k <= NR; k++) begin
                    if (!f && bus.s_tvalid[(md_last + k) % NR]) begin
                        f = 1;
                        p = (md_last + k) % NR;
                    end
                end
                md_busy = 1;
                md_own  = p;
                md_bc   = 0;
            end
        end else begin
            p = md_own;
            chk("grant", grant, 64'(1) << p);
            chk("busy", busy, 1);
            chk("m_tvalid", bus.m_tvalid, bus.s_tvalid[p]);
            chk("s_tready", bus.s_tready,
                bus.m_tready ? (64'(1) << p) : 64'(0));
            if (bus.s_tvalid[p]) begin
                b = q[p][0];
                chk("m_tdata", bus.m_tdata, b.d);
                chk("m_tkeep", bus.m_tkeep, b.k);
                chk("m_tuser", bus.m_tuser, b.u);
                chk("m_tlast", bus.m_tlast, b.l);
                if (bus.m_tready) begin
                    void'(q[p].pop_front());
                    md_bc++;
                    ovf = (md_bc == MB) && !b.l;
                    if (b.l) begin
                        md_busy = 0;
                        md_last = p;
                        done_q.push_back(p);
                        done_len.push_back(md_bc);
                    end
                end
            end
        end
        if (ovf && (!md_le || err_clr)) begin
            nle  = 1;
            nlep = p;
        end
        md_le  = nle;
        md_lep = nlep;
    endtask

    task automatic cycle();
        if (rnd) begin
            for (int i = 0; i < NR; i++)
                bub[i] = ($urandom_range(0, 3) == 0);
            bus.m_tready = ($urandom_range(0, 3) != 0);
        end
        drive();
        @(negedge clk);
        check_cycle();
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.s_tvalid = '1;
        bus.m_tready = 1'b1;
        #1;
        chk("rst_m_tvalid", bus.m_tvalid, 0);
        chk("rst_s_tready", bus.s_tready, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_len_err_port", len_err_port, 0);
        for (int i = 0; i < NR; i++) begin
            q[i].delete();
            bub[i] = 0;
        end
        done_q.delete();
        done_len.delete();
        md_reset();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_until(input int n, input int budget);
        int k;
        k = 0;
        while (done_q.size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk("timeout", done_q.size(), n);
    endtask

    task automatic wait_busy(input int budget);
        int k;
        k = 0;
        while (!md_busy && k < budget) begin
            cycle();
            k++;
        end
        chk("wait_busy", md_busy, 1);
    endtask

    initial begin
        beat_t b;
        int    c0;
        int    k;
        int    p;
        int    exp_ord[4];
        exp_ord = '{0, 1, 0, 1};
        bus.s_tvalid = '0;
        bus.s_tlast  = '0;
        bus.s_tdata  = '0;
        bus.s_tkeep  = '0;
        bus.s_tuser  = '0;
        bus.m_tready = 1'b1;
        md_reset();
        #2;
        do_reset();

        // Single-beat doorbell on port 0.
        link = 1'b1;
        b.d = 64'h00A0_2000_0101_0000;
        b.k = 8'hFF;
        b.u = 32'h00F0_00F1;
        b.l = 1'b1;
        q[0].push_back(b);
        mv_cnt = 0;
        mv_first = -1;
        c0 = ncyc;
        repeat (5) cycle();
        chk("db_mv_cycles", mv_cnt, 1);
        chk("db_mv_first", mv_first, c0 + 1);
        chk("db_done", done_q.size(), 1);

        // Two ports continuously valid, 3-beat packets.
        do_reset();
        link = 1'b1;
        enq(0, 3);
        enq(0, 3);
        enq(1, 3);
        enq(1, 3);
        run_until(4, 60);
        for (int i = 0; i < 4 && i < done_q.size(); i++) begin
            chk("rr_order", done_q[i], exp_ord[i]);
            chk("rr_len", done_len[i], 3);
        end

        // Port 1 with ready toggling while port 0 waits.
        done_q.delete();
        done_len.delete();
        enq(1, 4);
        wait_busy(5);
        enq(0, 2);
        k = 0;
        while (md_busy && k < 16) begin
            bus.m_tready = (k % 2 == 0);
            cycle();
            k++;
        end
        bus.m_tready = 1'b1;
        run_until(2, 30);
        if (done_q.size() == 2) begin
            chk("tog_first", done_q[0], 1);
            chk("tog_second", done_q[1], 0);
        end

        // Link gating.
        done_q.delete();
        done_len.delete();
        link = 1'b0;
        enq(0, 2);
        repeat (4) cycle();
        chk("nolink_grant", grant, 0);
        link = 1'b1;
        cycle();
        chk("link_grant", grant, 1);
        run_until(1, 20);
        done_q.delete();
        done_len.delete();
        enq(0, 4);
        wait_busy(5);
        cycle();
        link = 1'b0;
        enq(1, 1);
        repeat (12) cycle();
        chk("drop_done", done_q.size(), 1);
        if (done_len.size() > 0) chk("drop_len", done_len[0], 4);
        chk("drop_p1_pending", q[1].size(), 1);
        chk("drop_busy", busy, 0);
        link = 1'b1;
        run_until(2, 20);

        // Over-length packet and clear.
        done_q.delete();
        done_len.delete();
        enq(1, 34);
        run_until(1, 80);
        if (done_len.size() > 0) chk("long_len", done_len[0], 34);
        chk("long_err", len_err, 1);
        chk("long_err_port", len_err_port, 1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("clr_err", len_err, 0);
        chk("clr_port", len_err_port, 0);

        // Reset during beat 2.
        done_q.delete();
        done_len.delete();
        enq(0, 4);
        k = 0;
        while (!(md_busy && md_bc == 1) && k < 10) begin
            cycle();
            k++;
        end
        drive();
        #1;
        chk("b2_valid", bus.m_tvalid, 1);
        do_reset();
        link = 1'b1;
        enq(1, 2);
        enq(0, 2);
        run_until(2, 20);
        if (done_q.size() > 0) chk("post_rst_first", done_q[0], 0);

        // Random traffic.
        rnd = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(0, NR - 1);
                if (q[p].size() < 20)
                    enq(p, ($urandom_range(0, 11) == 0)
                           ? $urandom_range(33, 36)
                           : $urandom_range(1, 4));
            end
            link = ($urandom_range(0, 19) != 0);
            err_clr = ($urandom_range(0, 29) == 0);
            cycle();
        end
        rnd = 1'b0;
        for (int i = 0; i < NR; i++) bub[i] = 0;
        bus.m_tready = 1'b1;
        link = 1'b1;
        err_clr = 1'b0;
        k = 0;
        while ((q[0].size() > 0 || q[1].size() > 0 || md_busy)
               && k < 400) begin
            cycle();
            k++;
        end
        chk("drain_q0", q[0].size(), 0);
        chk("drain_q1", q[1].size(), 0);
        chk("drain_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ireq_arbiter.md
Name: ireq_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares the single SRIO logical-layer ireq AXI4-Stream master among NUM_REQ requesters, such as the doorbell self-check and the NWRITE user-data path.
- Sits between the requester blocks and the SRIO core ireq port.
- Holds a grant for a whole packet (header beat through tlast), gates new grants on link_initialized, and flags packets longer than MAX_BEATS.

Parameters:
- NUM_REQ, 2, number of requester ports (2..8).
- DATA_W, 64, tdata width; tkeep width is DATA_W/8.
- USER_W, 32, tuser width ({src_id, des_id}).
- MAX_BEATS, 33, maximum legal beats per packet (1 header + 32 payload beats of 8 bytes each).

Ports:
- log_clk  in  1  logical-layer clock; all logic on rising edge.
- log_rst_n  in  1  asynchronous, active-low reset.
- link_initialized  in  1  high = link up; new grants are allowed only while high.
- s_tvalid  in  NUM_REQ  per-requester valid.
- s_tready  out  NUM_REQ  per-requester ready.
- s_tlast  in  NUM_REQ  per-requester last.
- s_tdata  in  NUM_REQ*DATA_W  flattened; port i occupies [i*DATA_W +: DATA_W].
- s_tkeep  in  NUM_REQ*DATA_W/8  flattened, same packing.
- s_tuser  in  NUM_REQ*USER_W  flattened, same packing.
- m_tvalid  out  1  to core ireq_tvalid.
- m_tready  in  1  from core ireq_tready.
- m_tlast  out  1
- m_tdata  out  DATA_W
- m_tkeep  out  DATA_W/8
- m_tuser  out  USER_W
- grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- busy  out  1  high while a packet is owned.
- len_err  out  1  sticky over-length flag.
- len_err_port  out  3  index of the port that caused the first len_err.
- err_clr  in  1  synchronous clear of len_err and len_err_port.

Behaviour:
- Reset (log_rst_n low, asynchronous):
  - state = IDLE; grant = 0; busy = 0; len_err = 0; len_err_port = 0.
  - rr_ptr = NUM_REQ-1, so port 0 wins first.
  - beat_cnt = 0.
  - m_tvalid = 0 and s_tready = 0 while reset is asserted.
- FSM has two states, IDLE and XFER.
- IDLE:
  - m_tvalid = 0, all s_tready = 0, m_tdata/tkeep/tuser/tlast = 0.
  - If link_initialized and any s_tvalid: select the first valid port searching rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
  - Register that port as one-hot grant, set busy = 1, go to XFER.
  - Arbitration cost: exactly 1 idle cycle before the first beat of every packet.
- XFER (combinational path from the granted port):
  - m_* = s_*[g]; s_tready[g] = m_tready; s_tready of all other ports = 0.
  - A beat is accepted when m_tvalid && m_tready; beat_cnt increments per accepted beat (saturating, 8-bit).
  - On an accepted beat with m_tlast: rr_ptr <= g, grant <= 0, busy <= 0, beat_cnt <= 0, go to IDLE.
  - Granted requester deasserts tvalid mid-packet: grant is held; the bubble passes through to m_tvalid.
  - link_initialized falling mid-packet: the packet is still completed; only new grants are blocked.
- Over-length detection:
  - If a beat is accepted with beat_cnt == MAX_BEATS-1 and m_tlast = 0: len_err <= 1 and len_err_port <= g, only if len_err was 0.
  - Traffic is not altered; the packet continues to its own tlast.
- err_clr:
  - Clears len_err and len_err_port on the next edge.
  - If err_clr and a new error occur in the same cycle, the new error wins (set).
- Fairness:
  - A port that has just finished has lowest priority on the next arbitration.
  - With all ports continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- Single-beat packets (e.g. doorbell): header beat with tlast; grant is released after 1 accepted beat.
- Asynchronous reset mid-packet aborts the packet immediately; no partial-state recovery is attempted.

Test Plan:
- Reset then link_initialized = 1; port 0 sends 1-beat doorbell (tdata 64'h00A0_2000_0101_0000, tuser 32'h00F0_00F1), m_tready = 1 -> m_tvalid high for exactly 1 cycle, on the 2nd cycle after s_tvalid; m_tdata/m_tuser match; grant = 01 then 00.
- Ports 0 and 1 continuously valid, each sending 3-beat packets, m_tready = 1 -> packet order 0,1,0,1; one idle cycle between packets; no beat interleaving.
- Port 1 mid-packet with m_tready toggling 1,0,1,0 -> beats held stable while m_tready = 0; s_tready[0] stays 0 throughout; grant stays 10 until tlast accepted.
- link_initialized = 0 with port 0 valid -> no grant and m_tvalid = 0; raise link_initialized -> grant on the next cycle. Drop link_initialized during a 4-beat packet -> all 4 beats delivered, then no further grants.
- Port 1 sends 34 beats (MAX_BEATS = 33) -> len_err rises when the 33rd beat is accepted without tlast, len_err_port = 1, all 34 beats forwarded. Pulse err_clr -> len_err = 0 the next cycle.
- Assert log_rst_n low during beat 2 of a packet -> m_tvalid, grant, busy go to 0 immediately. After release, the port 0 request is granted first.
